// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, word-addressed data memory between the
// pipeline MEM stage (port 0) and the loader/debug port (port 1).
// Each request is latched in IDLE and issued to the memory for one ACCESS cycle.
// Read data returns one cycle later with a per-port rvalid pulse.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration;
// the default build uses fixed priority with port 0 winning.
module dmem_arbiter #(
    parameter int unsigned ADDR_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        err0,
    output logic        err1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]  stateQ, stateD;
    logic        ownerQ;
    logic        weQ;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic [31:0] rdataQ;
    logic        rvalid0Q, rvalid1Q;

    logic        winner;
    logic        latchReq;
    logic        inAccess;
    logic        inRange;

    // Byte-offset bits are ignored by a word-addressed memory.
    logic        unusedAddrBits;
    assign unusedAddrBits = ^{addr0[1:0], addr1[1:0]};

    assign inAccess = (stateQ == ACCESS);
    assign latchReq = (stateQ == IDLE) && (req0 || req1);

    // The upper bound guard keeps addresses at the very top of the space out of
    // range even when ADDR_LIMIT is close to 2^32.
    assign inRange = (addrQ <= 32'hFFFF_FFF8) && ((addrQ + 32'd3) < ADDR_LIMIT);

`ifdef DMEM_ARB_RR_EN
    logic lastOwnerQ;

    // Round-robin pick: on a conflict the port not served last wins.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~lastOwnerQ;
        end else begin
            winner = req1;
        end
    end

    // Remember which port was latched most recently; reset favours port 0 first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastOwnerQ <= 1'b1;
        end else if (latchReq) begin
            lastOwnerQ <= winner;
        end
    end
`else
    // Fixed priority pick: port 1 only wins when port 0 is idle.
    always_comb begin
        winner = ~req0;
    end
`endif

    // Next-state: IDLE -> ACCESS on any request, ACCESS always returns to IDLE.
    always_comb begin
        stateD = IDLE;
        if (stateQ == IDLE) begin
            stateD = latchReq ? ACCESS : IDLE;
        end
    end

    // State register and request latch; the latch only moves when entering ACCESS,
    // so the memory-side address/data hold their last value while IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
            ownerQ <= 1'b0;
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
        end else begin
            stateQ <= stateD;
            if (latchReq) begin
                ownerQ <= winner;
                weQ    <= winner ? we1 : we0;
                addrQ  <= winner ? {addr1[31:2], 2'b00} : {addr0[31:2], 2'b00};
                wdataQ <= winner ? wdata1 : wdata0;
            end
        end
    end

    // Read return path: capture data at the end of a read ACCESS, pulse rvalid next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdataQ   <= '0;
            rvalid0Q <= 1'b0;
            rvalid1Q <= 1'b0;
        end else begin
            rvalid0Q <= inAccess && !weQ && !ownerQ;
            rvalid1Q <= inAccess && !weQ && ownerQ;
            if (inAccess && !weQ) begin
                rdataQ <= inRange ? mem_rdata : 32'h0;
            end
        end
    end

    assign gnt0      = inAccess && !ownerQ;
    assign gnt1      = inAccess && ownerQ;
    assign err0      = gnt0 && !inRange;
    assign err1      = gnt1 && !inRange;
    assign rvalid0   = rvalid0Q;
    assign rvalid1   = rvalid1Q;
    assign rdata     = rdataQ;
    assign mem_adr   = addrQ;
    assign mem_wdata = wdataQ;
    // rst_n gates the strobe so an abandoned write cannot reach the memory.
    assign mem_write = rst_n && inAccess && weQ && inRange;

endmodule
